ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; consumes the ID/EX pipeline register outputs directly.
- Performs operand forwarding, ALU control decode, the single-cycle ALU and an iterative multi-cycle MUL.
- Registers the results into the EX/MEM pipeline register, which is held inside this block.
- Asserts stall_o to the hazard unit while a MUL is in flight.

---
 rtl/pipe_pkg.sv | 57 +++++
 rtl/mul_iter.sv | 48 ++++
 rtl/ex_stage.sv | 140 ++++++++++++++
 tb/tb_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the MIPS pipeline: ALU_OP/funct codes, control bit
// positions, internal ALU operation select and the execute-stage FSM states.
package pipe_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h18;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } ex_state_e;

  // Unknown R-type functs fall back to add.
  function automatic alu_op_e decode_alu(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_op_e sel;
    sel = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: sel = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_SUB:  sel = ALU_SUB;
          FN_AND:  sel = ALU_AND;
          FN_OR:   sel = ALU_OR;
          FN_SLT:  sel = ALU_SLT;
          FN_MUL:  sel = ALU_MUL;
          default: sel = ALU_ADD;
        endcase
      end
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring BPC multiplier bits per step, LSB first.
// The product output already includes the step in progress, so it is final while done is high.
module mul_iter #(
  parameter int BPC = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] product
);

  localparam int STEPS = 32 / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [31:0]    acc;
  logic [31:0]    mcand;
  logic [31:0]    mplier;
  logic [CW-1:0]  count;
  logic [BPC-1:0] digit;

  assign digit   = mplier[BPC-1:0];
  assign product = acc + (mcand * 32'(digit));
  assign done    = step && (count == CW'(STEPS - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      count  <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << BPC;
      mplier <= mplier >> BPC;
      count  <= done ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, iterative MUL and the EX/MEM register.
// stall_o holds the front of the pipe while a MUL occupies the stage.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  WB_i,
  input  logic [1:0]  MEM_i,
  input  logic        ALU_Src_i,
  input  logic [1:0]  ALU_OP_i,
  input  logic        Reg_Dst_i,
  input  logic [31:0] Reg_data1_i,
  input  logic [31:0] Reg_data2_i,
  input  logic [31:0] immd_i,
  input  logic [4:0]  RsAddr_FW_i,
  input  logic [4:0]  RtAddr_FW_i,
  input  logic [4:0]  RtAddr_WB_i,
  input  logic [4:0]  RdAddr_WB_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_Rd_i,
  input  logic [31:0] MEMWB_data_i,
  output logic [1:0]  WB_o,
  output logic [1:0]  MEM_o,
  output logic [31:0] ALUout_o,
  output logic [31:0] MemWriteData_o,
  output logic [4:0]  RegDst_o,
  output logic        stall_o
);

  ex_state_e   state;
  alu_op_e     alu_sel;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_result, mul_product;
  logic [4:0]  dest;
  logic        mul_start, mul_done;
  logic [1:0]  sh_wb, sh_mem;
  logic [4:0]  sh_dest;
  logic [31:0] sh_b;

  // EX/MEM wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_a = Reg_data1_i;
    if (WB_o[WB_REGWRITE] && RegDst_o != 5'd0 && RegDst_o == RsAddr_FW_i)
      fwd_a = ALUout_o;
    else if (MEMWB_RegWrite_i && MEMWB_Rd_i != 5'd0 && MEMWB_Rd_i == RsAddr_FW_i)
      fwd_a = MEMWB_data_i;
  end

  always_comb begin
    fwd_b = Reg_data2_i;
    if (WB_o[WB_REGWRITE] && RegDst_o != 5'd0 && RegDst_o == RtAddr_FW_i)
      fwd_b = ALUout_o;
    else if (MEMWB_RegWrite_i && MEMWB_Rd_i != 5'd0 && MEMWB_Rd_i == RtAddr_FW_i)
      fwd_b = MEMWB_data_i;
  end

  assign alu_b   = ALU_Src_i ? immd_i : fwd_b;
  assign dest    = Reg_Dst_i ? RdAddr_WB_i : RtAddr_WB_i;
  assign alu_sel = decode_alu(ALU_OP_i, immd_i[5:0]);

  // MUL results come from mul_iter; the single-cycle path only covers the other ops.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      ALU_ADD: alu_result = fwd_a + alu_b;
      ALU_SUB: alu_result = fwd_a - alu_b;
      ALU_AND: alu_result = fwd_a & alu_b;
      ALU_OR:  alu_result = fwd_a | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
  end

  assign mul_start = (state == ST_IDLE) && (alu_sel == ALU_MUL) && WB_i[WB_REGWRITE];
  assign stall_o   = mul_start || ((state == ST_BUSY) && !mul_done);

  mul_iter #(.BPC(BPC)) u_mul (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start   (mul_start),
    .step    (state == ST_BUSY),
    .a       (fwd_a),
    .b       (alu_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // EX/MEM register; inputs are ignored while BUSY since ID/EX keeps replaying the held instruction.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= ST_IDLE;
      WB_o           <= '0;
      MEM_o          <= '0;
      ALUout_o       <= '0;
      MemWriteData_o <= '0;
      RegDst_o       <= '0;
      sh_wb          <= '0;
      sh_mem         <= '0;
      sh_dest        <= '0;
      sh_b           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            sh_wb   <= WB_i;
            sh_mem  <= MEM_i;
            sh_dest <= dest;
            sh_b    <= fwd_b;
            WB_o    <= '0;
            MEM_o   <= '0;
            state   <= ST_BUSY;
          end else begin
            WB_o           <= WB_i;
            MEM_o          <= MEM_i;
            ALUout_o       <= alu_result;
            MemWriteData_o <= fwd_b;
            RegDst_o       <= dest;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            WB_o           <= sh_wb;
            MEM_o          <= sh_mem;
            ALUout_o       <= mul_product;
            MemWriteData_o <= sh_b;
            RegDst_o       <= sh_dest;
            state          <= ST_IDLE;
          end else begin
            WB_o  <= '0;
            MEM_o <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed plan steps followed by random instructions,
// all checked against a forwarding/arithmetic reference model of the EX/MEM register.
module tb_ex_stage;

  localparam int STEPS = 8;

  typedef struct {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic        src;
    logic [1:0]  op;
    logic        dst;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rtw;
    logic [4:0]  rdw;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_data;
  } instr_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  WB_i, MEM_i, ALU_OP_i;
  logic        ALU_Src_i, Reg_Dst_i, MEMWB_RegWrite_i;
  logic [31:0] Reg_data1_i, Reg_data2_i, immd_i, MEMWB_data_i;
  logic [4:0]  RsAddr_FW_i, RtAddr_FW_i, RtAddr_WB_i, RdAddr_WB_i, MEMWB_Rd_i;
  logic [1:0]  WB_o, MEM_o;
  logic [31:0] ALUout_o, MemWriteData_o;
  logic [4:0]  RegDst_o;
  logic        stall_o;

  int compared = 0;
  int mismatched = 0;

  logic [1:0]  m_wb, m_mem;
  logic [31:0] m_alu, m_mwd;
  logic [4:0]  m_dst;
  logic        m_alu_valid;

  ex_stage #(.BPC(4)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .WB_i             (WB_i),
    .MEM_i            (MEM_i),
    .ALU_Src_i        (ALU_Src_i),
    .ALU_OP_i         (ALU_OP_i),
    .Reg_Dst_i        (Reg_Dst_i),
    .Reg_data1_i      (Reg_data1_i),
    .Reg_data2_i      (Reg_data2_i),
    .immd_i           (immd_i),
    .RsAddr_FW_i      (RsAddr_FW_i),
    .RtAddr_FW_i      (RtAddr_FW_i),
    .RtAddr_WB_i      (RtAddr_WB_i),
    .RdAddr_WB_i      (RdAddr_WB_i),
    .MEMWB_RegWrite_i (MEMWB_RegWrite_i),
    .MEMWB_Rd_i       (MEMWB_Rd_i),
    .MEMWB_data_i     (MEMWB_data_i),
    .WB_o             (WB_o),
    .MEM_o            (MEM_o),
    .ALUout_o         (ALUout_o),
    .MemWriteData_o   (MemWriteData_o),
    .RegDst_o         (RegDst_o),
    .stall_o          (stall_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic instr_t nopInstr();
    instr_t t;
    t.wb = 2'b00; t.mem = 2'b00; t.src = 1'b0; t.op = 2'b00; t.dst = 1'b0;
    t.d1 = '0; t.d2 = '0; t.imm = '0; t.rs = '0; t.rt = '0; t.rtw = '0; t.rdw = '0;
    t.mw_we = 1'b0; t.mw_rd = '0; t.mw_data = '0;
    return t;
  endfunction

  function automatic instr_t randInstr();
    instr_t t;
    logic [5:0] fn_tab [7];
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h00};
    fn_tab[6] = 6'($urandom);
    t.wb      = 2'($urandom);
    t.mem     = 2'($urandom);
    t.src     = 1'($urandom);
    t.op      = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom);
    t.dst     = 1'($urandom);
    t.d1      = $urandom;
    t.d2      = $urandom;
    t.imm     = {$urandom} & 32'hFFFF_FFC0;
    t.imm[5:0] = fn_tab[$urandom_range(0, 6)];
    t.rs      = 5'($urandom_range(0, 7));
    t.rt      = 5'($urandom_range(0, 7));
    t.rtw     = 5'($urandom_range(0, 7));
    t.rdw     = 5'($urandom_range(0, 7));
    t.mw_we   = 1'($urandom);
    t.mw_rd   = 5'($urandom_range(0, 7));
    t.mw_data = $urandom;
    return t;
  endfunction

  function automatic logic [31:0] fwdModel(input logic [4:0] src, input logic [31:0] regval, input instr_t t);
    if (m_wb[1] && m_dst != 5'd0 && m_dst == src) return m_alu;
    if (t.mw_we && t.mw_rd != 5'd0 && t.mw_rd == src) return t.mw_data;
    return regval;
  endfunction

  function automatic logic isMul(input instr_t t);
    return (t.op == 2'b10) && (t.imm[5:0] == 6'h18);
  endfunction

  function automatic logic [31:0] aluModel(input instr_t t);
    logic [31:0] a, b;
    a = fwdModel(t.rs, t.d1, t);
    b = t.src ? t.imm : fwdModel(t.rt, t.d2, t);
    if (t.op == 2'b01) return a - b;
    if (t.op != 2'b10) return a + b;
    case (t.imm[5:0])
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h18:   return a * b;
      default: return a + b;
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input instr_t t);
    WB_i = t.wb; MEM_i = t.mem; ALU_Src_i = t.src; ALU_OP_i = t.op; Reg_Dst_i = t.dst;
    Reg_data1_i = t.d1; Reg_data2_i = t.d2; immd_i = t.imm;
    RsAddr_FW_i = t.rs; RtAddr_FW_i = t.rt; RtAddr_WB_i = t.rtw; RdAddr_WB_i = t.rdw;
    MEMWB_RegWrite_i = t.mw_we; MEMWB_Rd_i = t.mw_rd; MEMWB_data_i = t.mw_data;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " WB_o"}, 32'(WB_o), 32'(m_wb));
    checkValue({tag, " MEM_o"}, 32'(MEM_o), 32'(m_mem));
    if (m_alu_valid) checkValue({tag, " ALUout_o"}, ALUout_o, m_alu);
    checkValue({tag, " MemWriteData_o"}, MemWriteData_o, m_mwd);
    checkValue({tag, " RegDst_o"}, 32'(RegDst_o), 32'(m_dst));
  endtask

  task automatic resetModel();
    m_wb = '0; m_mem = '0; m_alu = '0; m_mwd = '0; m_dst = '0; m_alu_valid = 1'b1;
  endtask

  // Issues one instruction, walks a MUL through its occupancy, then checks EX/MEM.
  task automatic runInstr(input instr_t t, input string tag);
    logic [31:0] res, fb;
    logic [4:0]  dst;
    logic        long_op;
    res = aluModel(t);
    fb  = fwdModel(t.rt, t.d2, t);
    dst = t.dst ? t.rdw : t.rtw;
    long_op = isMul(t) && t.wb[1];
    applyStimulus(t);
    #1;
    checkValue({tag, " stall@issue"}, 32'(stall_o), long_op ? 32'd1 : 32'd0);
    step();
    if (long_op) begin
      for (int k = 1; k <= STEPS; k++) begin
        checkValue({tag, " bubble WB_o"}, 32'(WB_o), 32'd0);
        checkValue({tag, " busy stall"}, 32'(stall_o), (k < STEPS) ? 32'd1 : 32'd0);
        applyStimulus(randInstr());
        step();
      end
    end
    m_wb = t.wb; m_mem = t.mem; m_alu = res; m_mwd = fb; m_dst = dst;
    m_alu_valid = !(isMul(t) && !t.wb[1]);
    checkOutput(tag);
  endtask

  initial begin
    instr_t t;
    rst_n_i = 1'b0;
    applyStimulus(nopInstr());
    resetModel();
    repeat (2) @(negedge clk_i);
    #1;
    checkValue("reset stall", 32'(stall_o), 32'd0);
    checkOutput("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Reset asserted while the multiplier is at step 3.
    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h18; t.d1 = 32'h55; t.d2 = 32'h3;
    t.rs = 5'd1; t.rt = 5'd2; t.dst = 1'b1; t.rdw = 5'd5;
    applyStimulus(t);
    repeat (4) step();
    applyStimulus(nopInstr());
    rst_n_i = 1'b0;
    #1;
    resetModel();
    checkValue("midmul reset stall", 32'(stall_o), 32'd0);
    checkOutput("midmul reset");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h20; t.d1 = 7; t.d2 = 5;
    t.rs = 5'd1; t.rt = 5'd2; t.dst = 1'b1; t.rdw = 5'd3;
    runInstr(t, "add after reset");
    checkValue("add 7+5", ALUout_o, 32'd12);

    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h22; t.d1 = 0; t.d2 = 7;
    t.rs = 5'd3; t.rt = 5'd1; t.dst = 1'b1; t.rdw = 5'd4;
    runInstr(t, "sub exfwd");
    checkValue("sub exfwd value", ALUout_o, 32'd5);

    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h20; t.d1 = 32'hAA;
    t.rs = 5'd1; t.rt = 5'd2; t.dst = 1'b1; t.rdw = 5'd3;
    runInstr(t, "write3 AA");
    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h20; t.rs = 5'd3; t.rt = 5'd0;
    t.dst = 1'b1; t.rdw = 5'd8; t.mw_we = 1'b1; t.mw_rd = 5'd3; t.mw_data = 32'hBB;
    runInstr(t, "priority");
    checkValue("priority value", ALUout_o, 32'hAA);
    t.rdw = 5'd9;
    runInstr(t, "memwb only");
    checkValue("memwb only value", ALUout_o, 32'hBB);

    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h20; t.d1 = 32'hAA;
    t.rs = 5'd1; t.rt = 5'd2; t.dst = 1'b1; t.rdw = 5'd0;
    runInstr(t, "write0");
    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h20; t.d1 = 32'h11; t.rs = 5'd0;
    t.rt = 5'd0; t.dst = 1'b1; t.rdw = 5'd10; t.mw_we = 1'b1; t.mw_rd = 5'd0; t.mw_data = 32'hBB;
    runInstr(t, "r0 nofwd");
    checkValue("r0 nofwd value", ALUout_o, 32'h11);

    t = nopInstr(); t.wb = 2'b11; t.mem = 2'b10; t.src = 1'b1; t.op = 2'b00; t.d1 = 32'h100;
    t.imm = 32'hFFFF_FFFC; t.rs = 5'd1; t.rt = 5'd9; t.rtw = 5'd9; t.dst = 1'b0;
    runInstr(t, "lw");
    checkValue("lw addr", ALUout_o, 32'hFC);
    checkValue("lw dest", 32'(RegDst_o), 32'd9);
    checkValue("lw mem", 32'(MEM_o), 32'd2);

    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h2A; t.d1 = 32'hFFFF_FFFF; t.d2 = 1;
    t.rs = 5'd1; t.rt = 5'd2; t.dst = 1'b1; t.rdw = 5'd11;
    runInstr(t, "slt neg");
    checkValue("slt -1<1", ALUout_o, 32'd1);
    t.d1 = 1; t.d2 = 32'hFFFF_FFFF;
    runInstr(t, "slt pos");
    checkValue("slt 1<-1", ALUout_o, 32'd0);

    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h18; t.d1 = 32'h1234; t.d2 = 32'h10;
    t.rs = 5'd1; t.rt = 5'd2; t.dst = 1'b1; t.rdw = 5'd5;
    runInstr(t, "mul");
    checkValue("mul product", ALUout_o, 32'h12340);
    checkValue("mul dest", 32'(RegDst_o), 32'd5);
    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h20; t.rs = 5'd5; t.rt = 5'd0;
    t.dst = 1'b1; t.rdw = 5'd6;
    runInstr(t, "dep add");
    checkValue("dep add value", ALUout_o, 32'h12340);

    t = nopInstr(); t.wb = 2'b10; t.op = 2'b10; t.imm = 32'h18; t.rs = 5'd6; t.rt = 5'd2;
    t.d2 = 3; t.dst = 1'b1; t.rdw = 5'd7;
    runInstr(t, "mul b2b 1");
    t.rs = 5'd7; t.rdw = 5'd12;
    runInstr(t, "mul b2b 2");
    checkValue("mul b2b value", ALUout_o, 32'h12340 * 9);

    t = nopInstr(); t.op = 2'b10; t.imm = 32'h18; t.d1 = 3; t.d2 = 4;
    runInstr(t, "bubble mul");
    t = nopInstr(); t.wb = 2'b10; t.op = 2'b00; t.d1 = 1; t.d2 = 2; t.rs = 5'd13;
    t.rt = 5'd14; t.rtw = 5'd15;
    runInstr(t, "after bubble");

    for (int i = 0; i < 60; i++) begin
      runInstr(randInstr(), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
